// File: rtl/fft_pkg.sv
// fft_pkg: shared FFT constants, sample/state types and address bit reversal
package fft_pkg;
  localparam int BIT_WIDTH = 16;
  localparam int N = 9;
  typedef struct packed {
    logic signed [BIT_WIDTH-1:0] re;
    logic signed [BIT_WIDTH-1:0] im;
  } cplx_t;
  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
  function automatic logic [31:0] bitrev(input logic [31:0] a, input int n);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++)
      if (i < n) r[i] = a[n-1-i];
    return r;
  endfunction
endpackage

// File: rtl/fft_mag_est.sv
// fft_mag_est: magnitude estimate max(|re|,|im|) + min(|re|,|im|)/2 on W+1 bits
module fft_mag_est #(
  parameter int W = 16
) (
  input  logic [W-1:0] re_i,
  input  logic [W-1:0] im_i,
  output logic [W:0]   mag_o
);
  logic [W:0] re_x, im_x, abs_re, abs_im, mx, mn;
  // sign-extend by one bit so the most negative input has a representable magnitude
  always_comb begin
    re_x = {re_i[W-1], re_i};
    im_x = {im_i[W-1], im_i};
    abs_re = re_x[W] ? ~re_x + 1'b1 : re_x;
    abs_im = im_x[W] ? ~im_x + 1'b1 : im_x;
    mx = abs_re > abs_im ? abs_re : abs_im;
    mn = abs_re > abs_im ? abs_im : abs_re;
    mag_o = mx + (mn >> 1);
  end
endmodule

// File: rtl/fft_ram_reader.sv
// fft_ram_reader: walks the FFT RAM and streams {re,im,mag} beats on valid/ready
module fft_ram_reader #(
  parameter int BIT_WIDTH = 16,
  parameter int N = 9,
  parameter int BITREV = 0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  output logic                   ram_we,
  output logic [N-1:0]           ram_add,
  input  logic [2*BIT_WIDTH-1:0] ram_dout,
  output logic                   busy,
  output logic                   done,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [BIT_WIDTH-1:0]   out_re,
  output logic [BIT_WIDTH-1:0]   out_im,
  output logic [BIT_WIDTH:0]     out_mag,
  output logic [N-1:0]           out_idx,
  output logic                   out_last
);
  import fft_pkg::*;
  localparam logic [N:0] LAST = {1'b0, {N{1'b1}}};
  state_t state_q, state_d;
  logic [N:0] cnt_q, cnt_d;
  logic valid_q, valid_d, last_q, last_d, cap, acc;
  logic [BIT_WIDTH-1:0] re_q, re_d, im_q, im_d;
  logic [BIT_WIDTH:0] mag_q, mag_d, mag;
  logic [N-1:0] idx_q, idx_d;
  fft_mag_est #(.W(BIT_WIDTH)) u_mag (
    .re_i (ram_dout[2*BIT_WIDTH-1:BIT_WIDTH]),
    .im_i (ram_dout[BIT_WIDTH-1:0]),
    .mag_o(mag)
  );
  // a capture refills the output register whenever it is empty or being drained
  assign cap = state_q == READ && (!valid_q || out_ready);
  assign acc = valid_q && out_ready;
  // state, fetch counter and output beat register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      re_q    <= '0;
      im_q    <= '0;
      mag_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      re_q    <= re_d;
      im_q    <= im_d;
      mag_q   <= mag_d;
      idx_q   <= idx_d;
    end
  end
  // next state and next beat: RAM data is captured in the cycle its address is driven
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = READ;
      READ:    if (cap && cnt_q == LAST) state_d = DRAIN;
      DRAIN:   if (acc) state_d = DONE;
      default: state_d = IDLE;
    endcase
    cnt_d   = state_q == IDLE && start ? '0 : cap ? cnt_q + 1'b1 : cnt_q;
    valid_d = cap || (valid_q && !acc);
    re_d    = cap ? ram_dout[2*BIT_WIDTH-1:BIT_WIDTH] : re_q;
    im_d    = cap ? ram_dout[BIT_WIDTH-1:0] : im_q;
    mag_d   = cap ? mag : mag_q;
    idx_d   = cap ? cnt_q[N-1:0] : idx_q;
    last_d  = cap ? cnt_q == LAST : last_q;
  end
  // status flags and RAM address; the block never writes the RAM
  always_comb begin
    ram_we  = 1'b0;
    busy    = state_q == READ || state_q == DRAIN;
    done    = state_q == DONE;
    ram_add = BITREV != 0 ? N'(bitrev(32'(cnt_q[N-1:0]), N)) : cnt_q[N-1:0];
  end
  assign out_valid = valid_q;
  assign out_re    = re_q;
  assign out_im    = im_q;
  assign out_mag   = mag_q;
  assign out_idx   = idx_q;
  assign out_last  = last_q;
endmodule

// File: tb/tb_fft_ram_reader.sv
// tb_fft_ram_reader: scoreboard bench for the FFT RAM read sequencer
module tb_fft_ram_reader;
  localparam int W = 16;
  localparam int LA = 512;
  localparam int LB = 8;
  typedef struct {int re; int im; int mag; int idx; bit last;} beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, start_a, ready_a, start_b, ready_b;
  logic ram_we_a, busy_a, done_a, valid_a, last_a;
  logic ram_we_b, busy_b, done_b, valid_b, last_b;
  logic [8:0] add_a, idx_a;
  logic [2:0] add_b, idx_b;
  logic [31:0] dout_a, dout_b;
  logic [W-1:0] re_a, im_a, re_b, im_b;
  logic [W:0] mag_a, mag_b;
  logic [31:0] ram_a [LA];
  logic [31:0] ram_b [LB];
  assign dout_a = ram_a[add_a];
  assign dout_b = ram_b[add_b];

  fft_ram_reader #(.BIT_WIDTH(W), .N(9), .BITREV(0)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .ram_we(ram_we_a), .ram_add(add_a),
    .ram_dout(dout_a), .busy(busy_a), .done(done_a), .out_valid(valid_a), .out_ready(ready_a),
    .out_re(re_a), .out_im(im_a), .out_mag(mag_a), .out_idx(idx_a), .out_last(last_a));

  fft_ram_reader #(.BIT_WIDTH(W), .N(3), .BITREV(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .ram_we(ram_we_b), .ram_add(add_b),
    .ram_dout(dout_b), .busy(busy_b), .done(done_b), .out_valid(valid_b), .out_ready(ready_b),
    .out_re(re_b), .out_im(im_b), .out_mag(mag_b), .out_idx(idx_b), .out_last(last_b));

  int vectors = 0, miscompares = 0;
  beat_t q_a[$], q_b[$];
  int cyc = 0, acc_cnt_a = 0, first_cyc = 0, last_cyc = 0;
  bit done_exp = 0, stall_prev = 0, rnd_ready = 0;
  logic [58:0] snap_prev;
  wire [58:0] snap_a = {re_a, im_a, mag_a, idx_a, last_a};

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int mag_of(int re, int im);
    int ar, ai;
    ar = re < 0 ? -re : re;
    ai = im < 0 ? -im : im;
    return ar > ai ? ar + ai / 2 : ai + ar / 2;
  endfunction

  function automatic beat_t mk(logic [31:0] w, int idx, int len);
    beat_t b;
    b.re = int'($signed(w[31:16]));
    b.im = int'($signed(w[15:0]));
    b.mag = mag_of(b.re, b.im);
    b.idx = idx;
    b.last = idx == len - 1;
    return b;
  endfunction

  task automatic push_frame_a();
    for (int k = 0; k < LA; k++) q_a.push_back(mk(ram_a[k], k, LA));
  endtask

  // monitor for the natural-order instance: scoreboard pop, hold-under-stall, done timing
  always @(negedge clk) begin
    cyc++;
    if (!reset_n) begin
      stall_prev = 0;
      done_exp = 0;
    end else begin
      check("ram_we_a", ram_we_a, 0);
      check("done_a", done_a, done_exp);
      done_exp = 0;
      if (stall_prev) check("hold_a", snap_a, snap_prev);
      if (valid_a) check("busy_a", busy_a, 1);
      if (valid_a && ready_a) begin
        if (q_a.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL extra_beat_a: got idx %0d expected no beat", idx_a);
        end else begin
          beat_t e;
          e = q_a.pop_front();
          check("re_a", $signed(re_a), e.re);
          check("im_a", $signed(im_a), e.im);
          check("mag_a", mag_a, e.mag);
          check("idx_a", idx_a, e.idx);
          check("last_a", last_a, e.last);
          if (e.idx == 0) first_cyc = cyc;
          last_cyc = cyc;
          done_exp = e.last;
        end
        acc_cnt_a++;
      end
      stall_prev = valid_a && !ready_a;
      snap_prev = snap_a;
    end
  end

  // monitor for the bit-reversed instance
  always @(negedge clk) begin
    if (reset_n) begin
      check("ram_we_b", ram_we_b, 0);
      if (valid_b && ready_b) begin
        if (q_b.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL extra_beat_b: got idx %0d expected no beat", idx_b);
        end else begin
          beat_t e;
          e = q_b.pop_front();
          check("re_b", $signed(re_b), e.re);
          check("im_b", $signed(im_b), e.im);
          check("mag_b", mag_b, e.mag);
          check("idx_b", idx_b, e.idx);
          check("last_b", last_b, e.last);
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rnd_ready) ready_a = 1'($urandom_range(0, 1));
  end

  task automatic pulse_a();
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
  endtask

  task automatic wait_empty_a(input string name);
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (q_a.size() == 0) return;
    end
    vectors++;
    miscompares++;
    $display("FAIL %s: timeout with %0d beats outstanding, expected 0", name, q_a.size());
  endtask

  task automatic wait_beats_a(input int n);
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (acc_cnt_a >= n) return;
    end
    vectors++;
    miscompares++;
    $display("FAIL wait_beats: got %0d beats expected %0d", acc_cnt_a, n);
  endtask

  task automatic check_cleared(input string name);
    check({name, "_valid"}, valid_a, 0);
    check({name, "_busy"}, busy_a, 0);
    check({name, "_done"}, done_a, 0);
    check({name, "_add"}, add_a, 0);
    check({name, "_outs"}, snap_a, 0);
  endtask

  task automatic fill_random_a();
    for (int k = 0; k < LA; k++) ram_a[k] = $urandom;
  endtask

  initial begin
    int tbl [LB] = '{0, 4, 2, 6, 1, 5, 3, 7};
    reset_n = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    ready_a = 1'b1;
    ready_b = 1'b1;
    for (int k = 0; k < LA; k++) ram_a[k] = {16'(k), 16'(-k)};
    for (int a = 0; a < LB; a++) ram_b[a] = {16'(a), 16'(-a)};
    repeat (3) @(posedge clk);
    #1 check_cleared("reset");
    reset_n = 1'b1;

    // natural order frame with ready held high: gap-free, done right after beat 511
    push_frame_a();
    pulse_a();
    wait_empty_a("frame1");
    repeat (3) @(negedge clk);
    check("frame1_span", last_cyc - first_cyc, LA - 1);
    check("frame1_busy", busy_a, 0);

    // bit-reversed 8-point frame
    for (int i = 0; i < LB; i++) q_b.push_back(mk(ram_b[tbl[i]], i, LB));
    @(posedge clk); #1 start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    for (int i = 0; i < 100 && q_b.size() != 0; i++) @(negedge clk);
    check("frame_b_left", q_b.size(), 0);

    // random data with magnitude corner cases, random ready, stray starts
    fill_random_a();
    ram_a[0] = {16'sd3, 16'sd4};
    ram_a[1] = {16'h8000, 16'h0000};
    ram_a[2] = {16'h8000, 16'h8000};
    ram_a[3] = 32'h0;
    check("mag_3_4", mag_of(3, 4), 5);
    check("mag_min_0", mag_of(-32768, 0), 32768);
    check("mag_min_min", mag_of(-32768, -32768), 49152);
    push_frame_a();
    acc_cnt_a = 0;
    rnd_ready = 1;
    pulse_a();
    wait_beats_a(100);
    pulse_a();
    wait_empty_a("frame2");
    for (int i = 0; i < 20 && !done_a; i++) @(negedge clk);
    check("frame2_done", done_a, 1);
    start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    rnd_ready = 0;
    ready_a = 1'b1;
    repeat (5) @(negedge clk);
    check("done_start_busy", busy_a, 0);
    check("done_start_valid", valid_a, 0);

    // reset mid-frame, then a fresh frame from bin 0
    fill_random_a();
    push_frame_a();
    acc_cnt_a = 0;
    pulse_a();
    wait_beats_a(200);
    @(posedge clk); #1;
    check("pre_reset_valid", valid_a, 1);
    reset_n = 1'b0;
    q_a.delete();
    #1 check_cleared("midreset");
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    fill_random_a();
    push_frame_a();
    pulse_a();
    wait_empty_a("frame3");
    repeat (3) @(negedge clk);
    check("frame3_busy", busy_a, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
